stream_rr_arbiter: RTL and testbench

- Two-requester, round-robin, burst-granting arbiter that merges two 32-bit host-side streams into one firmware output stream.
- Sits in front of a single shared stream consumer, such as a PC-bound output stream or a summing/processing kernel, that more than one producer must feed.
- Output is a one-entry registered stage with valid/rdy semantics. Each output word is tagged with the index of the stream it came from.

---
 rtl/stream_rr_arbiter.sv | 147 ++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// Two-input round-robin burst arbiter merging two 32-bit valid/rdy streams into
// one registered output stage, tagging each word with its source stream.
module stream_rr_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        s1i_valid,
    output logic        s1i_rdy,
    input  logic [31:0] s1i_data,

    input  logic        s2i_valid,
    output logic        s2i_rdy,
    input  logic [31:0] s2i_data,

    output logic        s1o_valid,
    input  logic        s1o_rdy,
    output logic [31:0] s1o_data,
    output logic        s1o_src,

    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT1 = 2'd1,
        GRANT2 = 2'd2
    } stateE;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    stateE             stateQ, stateD;
    logic [CNT_W-1:0]  beatCntQ, beatCntD;
    logic              lastSrvQ, lastSrvD;
    logic              outFullQ;
    logic [31:0]       outDataQ;
    logic              outSrcQ;

    logic              loadOk;
    logic              curValid;
    logic              otherValid;
    logic              accept;
    logic              relGrant;

    // The output slot can take a new word when empty or when it drains this cycle.
    assign loadOk = ~outFullQ | s1o_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= IDLE;
            beatCntQ <= '0;
            lastSrvQ <= 1'b1;
        end else begin
            stateQ   <= stateD;
            beatCntQ <= beatCntD;
            lastSrvQ <= lastSrvD;
        end
    end

    always_comb begin
        stateD     = stateQ;
        beatCntD   = beatCntQ;
        lastSrvD   = lastSrvQ;
        curValid   = 1'b0;
        otherValid = 1'b0;
        accept     = 1'b0;
        relGrant   = 1'b0;
        unique case (stateQ)
            IDLE: begin
                // lastSrvQ=1 means stream 2 was served last, so stream 1 wins a tie.
                if (s1i_valid && s2i_valid) begin
                    stateD = lastSrvQ ? GRANT1 : GRANT2;
                end else if (s1i_valid) begin
                    stateD = GRANT1;
                end else if (s2i_valid) begin
                    stateD = GRANT2;
                end
            end
            GRANT1, GRANT2: begin
                curValid   = (stateQ == GRANT1) ? s1i_valid : s2i_valid;
                otherValid = (stateQ == GRANT1) ? s2i_valid : s1i_valid;
                accept     = curValid & loadOk;
                relGrant   = (accept && (beatCntQ == LAST_BEAT)) || (loadOk && !curValid);
                if (relGrant) begin
                    beatCntD = '0;
                    lastSrvD = (stateQ == GRANT2);
                    if (otherValid) begin
                        stateD = (stateQ == GRANT1) ? GRANT2 : GRANT1;
                    end else if (curValid) begin
                        stateD = stateQ;
                    end else begin
                        stateD = IDLE;
                    end
                end else if (accept) begin
                    beatCntD = beatCntQ + 1'b1;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_comb begin
        s1i_rdy = 1'b0;
        s2i_rdy = 1'b0;
        grant   = 2'b00;
        unique case (stateQ)
            GRANT1: begin
                s1i_rdy = loadOk;
                grant   = 2'b01;
            end
            GRANT2: begin
                s2i_rdy = loadOk;
                grant   = 2'b10;
            end
            default: begin
                s1i_rdy = 1'b0;
                s2i_rdy = 1'b0;
                grant   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outFullQ <= 1'b0;
            outDataQ <= '0;
            outSrcQ  <= 1'b0;
        end else if (s1i_valid && s1i_rdy) begin
            outFullQ <= 1'b1;
            outDataQ <= s1i_data;
            outSrcQ  <= 1'b0;
        end else if (s2i_valid && s2i_rdy) begin
            outFullQ <= 1'b1;
            outDataQ <= s2i_data;
            outSrcQ  <= 1'b1;
        end else if (s1o_rdy) begin
            outFullQ <= 1'b0;
        end
    end

    assign s1o_valid = outFullQ;
    assign s1o_data  = outDataQ;
    assign s1o_src   = outSrcQ;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: cycle-level reference model plus directed
// scenarios with literal expected output sequences, then randomized traffic.
module tb_stream_rr_arbiter;

    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        s1i_valid, s1i_rdy;
    logic [31:0] s1i_data;
    logic        s2i_valid, s2i_rdy;
    logic [31:0] s2i_data;
    logic        s1o_valid, s1o_rdy;
    logic [31:0] s1o_data;
    logic        s1o_src;
    logic [1:0]  grant;

    stream_rr_arbiter #(.BURST_LEN(BL), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .s1i_valid (s1i_valid),
        .s1i_rdy   (s1i_rdy),
        .s1i_data  (s1i_data),
        .s2i_valid (s2i_valid),
        .s2i_rdy   (s2i_rdy),
        .s2i_data  (s2i_data),
        .s1o_valid (s1o_valid),
        .s1o_rdy   (s1o_rdy),
        .s1o_data  (s1o_data),
        .s1o_src   (s1o_src),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycNum = 0;

    // Source drivers: words left to send, enable, and the word currently presented.
    int          s1Left = 0, s2Left = 0;
    bit          s1En = 0, s2En = 0;
    logic [31:0] s1Next = '0, s2Next = '0;

    // Reference model: owner 0=none,1,2; lastSrv is the stream served most recently.
    int          mOwner = 0;
    int          mBeats = 0;
    int          mLast  = 2;
    bit          mFull  = 0;
    logic [31:0] mData  = '0;
    bit          mSrc   = 0;

    logic [32:0] outLog[$];
    int          outCyc[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycNum);
        end
    endtask

    task automatic applyStimulus(input bit en1, input bit en2, input bit rdy, input bit rstIn);
        s1En      = en1;
        s2En      = en2;
        rst       = rstIn;
        s1o_rdy   = rdy;
        s1i_valid = s1En && (s1Left > 0);
        s1i_data  = s1Next;
        s2i_valid = s2En && (s2Left > 0);
        s2i_data  = s2Next;
    endtask

    task automatic step(input bit en1, input bit en2, input bit rdy, input bit rstIn);
        applyStimulus(en1, en2, rdy, rstIn);
        @(posedge clk);
        #1;
    endtask

    // Compare DUT against the model mid-cycle, then advance the model past the coming edge.
    always @(negedge clk) begin
        bit loadOk, v1, v2, myV, otherV, acc, done;
        cycNum++;
        loadOk = !mFull || s1o_rdy;
        checkOutput("s1o_valid", 64'(s1o_valid), 64'(mFull));
        checkOutput("grant", 64'(grant), (mOwner == 1) ? 64'd1 : (mOwner == 2) ? 64'd2 : 64'd0);
        checkOutput("s1i_rdy", 64'(s1i_rdy), 64'(mOwner == 1 && loadOk));
        checkOutput("s2i_rdy", 64'(s2i_rdy), 64'(mOwner == 2 && loadOk));
        if (mFull) begin
            checkOutput("s1o_data", 64'(s1o_data), 64'(mData));
            checkOutput("s1o_src", 64'(s1o_src), 64'(mSrc));
        end
        if (s1o_valid === 1'b1 && s1o_rdy) begin
            outLog.push_back({s1o_src, s1o_data});
            outCyc.push_back(cycNum);
        end

        v1 = (s1i_valid === 1'b1);
        v2 = (s2i_valid === 1'b1);
        if (rst) begin
            mOwner = 0; mBeats = 0; mLast = 2; mFull = 0; mData = '0; mSrc = 0;
        end else begin
            myV    = (mOwner == 1) ? v1 : v2;
            otherV = (mOwner == 1) ? v2 : v1;
            acc    = (mOwner != 0) && myV && loadOk;
            if (acc) begin
                mFull = 1;
                mSrc  = (mOwner == 2);
                if (mOwner == 1) begin
                    mData = s1Next; s1Left--; s1Next++;
                end else begin
                    mData = s2Next; s2Left--; s2Next++;
                end
            end else if (s1o_rdy) begin
                mFull = 0;
            end
            if (mOwner == 0) begin
                if (v1 && v2) mOwner = (mLast == 1) ? 2 : 1;
                else if (v1)  mOwner = 1;
                else if (v2)  mOwner = 2;
            end else begin
                done = (acc && (mBeats + 1 == BL)) || (loadOk && !myV);
                if (done) begin
                    mLast  = mOwner;
                    mBeats = 0;
                    mOwner = otherV ? (3 - mOwner) : (myV ? mOwner : 0);
                end else if (acc) begin
                    mBeats++;
                end
            end
        end
    end

    task automatic resetDut;
        step(0, 0, 1, 1);
        checkOutput("reset s1o_valid", 64'(s1o_valid), 64'd0);
        checkOutput("reset grant", 64'(grant), 64'd0);
        checkOutput("reset s1i_rdy", 64'(s1i_rdy), 64'd0);
        checkOutput("reset s2i_rdy", 64'(s2i_rdy), 64'd0);
        outLog.delete();
        outCyc.delete();
    endtask

    task automatic checkContentionLog(input string name);
        logic [32:0] expWord;
        checkOutput({name, " count"}, 64'(outLog.size() >= 16), 64'd1);
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < BL; j++) begin
                expWord = {b[0], ((b[0] ? 32'h20 : 32'h10) + 32'(b / 2 * BL + j))};
                if (outLog.size() > b * BL + j)
                    checkOutput(name, 64'(outLog[b * BL + j]), 64'(expWord));
            end
        end
    endtask

    initial begin
        int firstCyc;
        s1o_rdy = 1'b1;
        step(0, 0, 1, 1);
        resetDut();

        // Single stream, 6 words back to back, regranted after the 4-beat burst.
        s1Next = 32'h1; s1Left = 6;
        firstCyc = cycNum + 1;
        repeat (10) step(1, 0, 1, 0);
        checkOutput("single count", 64'(outLog.size()), 64'd6);
        for (int i = 0; i < 6 && i < outLog.size(); i++)
            checkOutput("single word", 64'(outLog[i]), 64'({1'b0, 32'(i + 1)}));
        if (outLog.size() == 6) begin
            checkOutput("single latency", 64'(outCyc[0] - firstCyc), 64'd2);
            checkOutput("single no bubble", 64'(outCyc[5] - outCyc[0]), 64'd5);
        end

        // Contention from reset: stream 1 wins the first tie, bursts of 4 alternate.
        resetDut();
        s1Next = 32'h10; s2Next = 32'h20; s1Left = 100; s2Left = 100;
        step(1, 1, 1, 0);
        checkOutput("tie grant after reset", 64'(grant), 64'd1);
        repeat (19) step(1, 1, 1, 0);
        checkContentionLog("contention word");
        if (outLog.size() >= 16)
            checkOutput("contention no idle", 64'(outCyc[15] - outCyc[0]), 64'd15);

        // Same traffic with downstream ready toggling.
        resetDut();
        s1Next = 32'h10; s2Next = 32'h20; s1Left = 100; s2Left = 100;
        for (int i = 0; i < 40; i++) step(1, 1, (i % 2) == 0, 0);
        checkContentionLog("backpressure word");

        // Early release: s2 sends two words then goes idle while s1 waits.
        resetDut();
        s1Next = 32'h10; s1Left = 4; s2Next = 32'h20; s2Left = 2;
        step(0, 1, 1, 0);
        repeat (8) step(1, 1, 1, 0);
        checkOutput("early count", 64'(outLog.size() >= 3), 64'd1);
        if (outLog.size() >= 3) begin
            checkOutput("early w0", 64'(outLog[0]), 64'({1'b1, 32'h20}));
            checkOutput("early w1", 64'(outLog[1]), 64'({1'b1, 32'h21}));
            checkOutput("early w2", 64'(outLog[2]), 64'({1'b0, 32'h10}));
            checkOutput("early gap", 64'(outCyc[2] - outCyc[1]), 64'd2);
        end

        // Tie in IDLE after stream 1 was last served goes to stream 2.
        resetDut();
        s1Next = 32'h30; s1Left = 1;
        repeat (4) step(1, 0, 1, 0);
        s1Left = 2; s2Next = 32'h40; s2Left = 2;
        step(1, 1, 1, 0);
        checkOutput("tie grant after s1", 64'(grant), 64'd2);
        repeat (8) step(1, 1, 1, 0);

        // Reset mid-burst while stream 2 holds the grant and the output is full.
        resetDut();
        s1Next = 32'h10; s2Next = 32'h20; s1Left = 100; s2Left = 100;
        repeat (6) step(1, 1, 1, 0);
        checkOutput("pre-reset grant", 64'(grant), 64'd2);
        checkOutput("pre-reset valid", 64'(s1o_valid), 64'd1);
        step(1, 1, 0, 1);
        checkOutput("post-reset valid", 64'(s1o_valid), 64'd0);
        checkOutput("post-reset grant", 64'(grant), 64'd0);
        checkOutput("post-reset s1i_rdy", 64'(s1i_rdy), 64'd0);
        checkOutput("post-reset s2i_rdy", 64'(s2i_rdy), 64'd0);
        step(1, 1, 1, 0);
        checkOutput("post-reset tie grant", 64'(grant), 64'd1);

        // Randomized traffic, backpressure and occasional resets.
        resetDut();
        s1Next = 32'h1000_0000; s2Next = 32'h2000_0000; s1Left = 1000000; s2Left = 1000000;
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 299) == 0);
        for (int i = 0; i < 2000; i++)
            step(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
